sevenseg_scan_driver: RTL and testbench

- Output-side driver for the board's 8-digit, common-anode seven-segment display. It takes a 32-bit hex value plus a per-digit blank mask from the processor over a single-cycle write strobe.
- It scans the digits in time-multiplexed fashion on SevenSegAn/SevenSegCat, which are active-low.
- Written values are double-buffered and applied only at frame boundaries, so a write never tears a frame.
- Sits between the processor's memory-mapped output register and the top-level display pins.

---
 rtl/sevenseg_scan_driver_if.sv | 21 ++
 rtl/sevenseg_scan_driver.sv | 99 +++++++++
 tb/tb_sevenseg_scan_driver.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_driver_if.sv
// Processor write port plus display pins for the eight-digit scanned seven-segment driver.
// The slave side belongs to the driver; the master side belongs to the register block or bench.
interface sevenseg_scan_driver_if;
   logic        WrEn;
   logic [31:0] WrData;
   logic [7:0]  WrBlank;
   logic [7:0]  SevenSegAn;
   logic [6:0]  SevenSegCat;
   logic        FrameDone;
   logic        UpdPending;

   modport slave (
      input  WrEn, WrData, WrBlank,
      output SevenSegAn, SevenSegCat, FrameDone, UpdPending
   );

   modport master (
      output WrEn, WrData, WrBlank,
      input  SevenSegAn, SevenSegCat, FrameDone, UpdPending
   );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed 8-digit common-anode driver; writes are held until the frame boundary.
// Outputs are registered one cycle behind digit/active state; writes are always accepted.
module sevenseg_scan_driver #(
   parameter int SCAN_DIV = 100000
) (
   input  logic                  CLK,
   input  logic                  Reset,
   sevenseg_scan_driver_if.slave bus
);
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] presc;
   logic [2:0]    digit;
   logic [31:0]   act_data;
   logic [31:0]   pend_data;
   logic [7:0]    act_blank;
   logic [7:0]    pend_blank;
   logic          upd_pending;
   logic          frame_done;
   logic [7:0]    an_q;
   logic [6:0]    cat_q;

   logic          tick;
   logic          boundary;
   logic [3:0]    nibble;
   logic [6:0]    seg;

   assign tick     = (presc == CW'(SCAN_DIV - 1));
   assign boundary = tick && (digit == 3'd7);
   assign nibble   = act_data[{digit, 2'b00} +: 4];

   always_comb begin
      seg = 7'h7F;
      case (nibble)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         presc       <= '0;
         digit       <= 3'd0;
         act_data    <= 32'h0;
         act_blank   <= 8'h00;
         pend_data   <= 32'h0;
         pend_blank  <= 8'h00;
         upd_pending <= 1'b0;
         frame_done  <= 1'b0;
         an_q        <= 8'hFF;
         cat_q       <= 7'h7F;
      end else begin
         presc <= tick ? '0 : presc + CW'(1);
         if (tick) begin
            digit <= digit + 3'd1;
         end

         // A write landing on the boundary itself bypasses the pending buffer so the newest value wins.
         if (boundary) begin
            if (bus.WrEn) begin
               act_data  <= bus.WrData;
               act_blank <= bus.WrBlank;
            end else if (upd_pending) begin
               act_data  <= pend_data;
               act_blank <= pend_blank;
            end
            upd_pending <= 1'b0;
         end else if (bus.WrEn) begin
            pend_data   <= bus.WrData;
            pend_blank  <= bus.WrBlank;
            upd_pending <= 1'b1;
         end

         frame_done <= boundary;
         an_q       <= act_blank[digit] ? 8'hFF : ~(8'b1 << digit);
         cat_q      <= act_blank[digit] ? 7'h7F : seg;
      end
   end

   assign bus.SevenSegAn  = an_q;
   assign bus.SevenSegCat = cat_q;
   assign bus.FrameDone   = frame_done;
   assign bus.UpdPending  = upd_pending;
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with SCAN_DIV=3 (one frame = 24 cycles).
// k counts rising edges since reset release; outputs are sampled on the falling edge.
module tb_sevenseg_scan_driver;
   logic CLK;
   logic Reset;
   int   tests;
   int   fails;
   int   k;

   sevenseg_scan_driver_if bus ();

   sevenseg_scan_driver #(.SCAN_DIV(3)) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) @(posedge CLK);
      @(negedge CLK);
      k = k + n;
   endtask

   task automatic idle_to(input int target);
      if (target > k) adv(target - k);
   endtask

   task automatic wr(input logic [31:0] data, input logic [7:0] blank);
      bus.WrEn    = 1'b1;
      bus.WrData  = data;
      bus.WrBlank = blank;
      adv(1);
      bus.WrEn    = 1'b0;
   endtask

   // Checks every cycle of one frame; call with k a multiple of 24. cats[7d +: 7] is digit d.
   task automatic check_frame(input string tag, input logic [55:0] cats, input logic [7:0] blank);
      logic [7:0] exp_an;
      for (int d = 0; d < 8; d++) begin
         exp_an = blank[d] ? 8'hFF : ~(8'b1 << d);
         for (int s = 0; s < 3; s++) begin
            adv(1);
            chk($sformatf("%s an d%0d s%0d", tag, d, s), {24'h0, bus.SevenSegAn}, {24'h0, exp_an});
            chk($sformatf("%s cat d%0d s%0d", tag, d, s), {25'h0, bus.SevenSegCat}, {25'h0, cats[7*d +: 7]});
            chk($sformatf("%s fd d%0d s%0d", tag, d, s), {31'h0, bus.FrameDone},
                {31'h0, (d == 7 && s == 2) ? 1'b1 : 1'b0});
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " an"},  {24'h0, bus.SevenSegAn},  32'hFF);
      chk({tag, " cat"}, {25'h0, bus.SevenSegCat}, 32'h7F);
      chk({tag, " fd"},  {31'h0, bus.FrameDone},   32'h0);
      chk({tag, " upd"}, {31'h0, bus.UpdPending},  32'h0);
   endtask

   initial begin
      tests       = 0;
      fails       = 0;
      k           = 0;
      Reset       = 1'b1;
      bus.WrEn    = 1'b0;
      bus.WrData  = 32'h0;
      bus.WrBlank = 8'h00;

      for (int i = 0; i < 3; i++) begin
         adv(1);
         check_reset_outputs($sformatf("rst%0d", i));
      end
      Reset = 1'b0;
      k     = 0;

      // Idle scanning, two frames of zeros.
      check_frame("idle0", {8{7'h40}}, 8'h00);
      check_frame("idle1", {8{7'h40}}, 8'h00);

      // Mid-frame write at digit 2, applied at the next boundary.
      idle_to(55);
      wr(32'h76543210, 8'h00);
      chk("wr_upd_set", {31'h0, bus.UpdPending}, 32'h1);
      idle_to(60);
      chk("hold_an", {24'h0, bus.SevenSegAn}, 32'hF7);
      chk("hold_cat", {25'h0, bus.SevenSegCat}, 32'h40);
      idle_to(71);
      chk("upd_before_bnd", {31'h0, bus.UpdPending}, 32'h1);
      idle_to(72);
      chk("upd_after_bnd", {31'h0, bus.UpdPending}, 32'h0);
      chk("fd_bnd", {31'h0, bus.FrameDone}, 32'h1);
      check_frame("seq", {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}, 8'h00);

      // Two writes in one frame: last wins, old frame untouched meanwhile.
      idle_to(99);
      wr(32'h11111111, 8'h00);
      idle_to(109);
      wr(32'hFFFFFFFF, 8'h00);
      idle_to(112);
      chk("lastwin_hold_an", {24'h0, bus.SevenSegAn}, 32'hDF);
      chk("lastwin_hold_cat", {25'h0, bus.SevenSegCat}, 32'h12);
      idle_to(120);
      check_frame("lastwin", {8{7'h0E}}, 8'h00);

      // Write in the boundary cycle while another value is pending.
      idle_to(150);
      wr(32'h22222222, 8'h00);
      chk("byp_upd_set", {31'h0, bus.UpdPending}, 32'h1);
      idle_to(167);
      wr(32'hABCDEF98, 8'h00);
      chk("byp_upd_clr", {31'h0, bus.UpdPending}, 32'h0);
      chk("byp_fd", {31'h0, bus.FrameDone}, 32'h1);
      check_frame("bypass", {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h10, 7'h00}, 8'h00);
      chk("byp_upd_end", {31'h0, bus.UpdPending}, 32'h0);

      // Blank mask on the upper four digits.
      idle_to(200);
      wr(32'h12345678, 8'hF0);
      idle_to(216);
      check_frame("blank", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h02, 7'h78, 7'h00}, 8'hF0);

      // Reset mid-frame with a write pending: the write must be discarded.
      idle_to(245);
      wr(32'hFFFFFFFF, 8'h00);
      chk("rst_pend_set", {31'h0, bus.UpdPending}, 32'h1);
      Reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         adv(1);
         check_reset_outputs($sformatf("midrst%0d", i));
      end
      Reset = 1'b0;
      k     = 0;
      check_frame("postrst0", {8{7'h40}}, 8'h00);
      chk("postrst_upd", {31'h0, bus.UpdPending}, 32'h0);
      check_frame("postrst1", {8{7'h40}}, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
